// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller states, frame constants, parity helper
// and the common host command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic       PS2_START       = 1'b0;
  localparam logic       PS2_STOP        = 1'b1;
  localparam int         PS2_FRAME_EDGES = 11;

  localparam logic [7:0] CMD_SET_LED     = 8'hED;
  localparam logic [7:0] CMD_RESET       = 8'hFF;
  localparam logic [7:0] ACK_BYTE        = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Multi-flop synchronizer for one PS/2 pad plus a falling-edge detector on the
// synchronized level. Flops reset high to match an idle (released) bus.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic pad,
  output logic level,
  output logic fe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign fe    = prev_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends start/data/parity/stop
// on device clock edges, checks the device ack and reports done or an error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err,
  output ps2_state_e state_dbg
);

  localparam int              IW        = $clog2(INHIBIT_CYCLES + 1);
  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0]   INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  // Loaded with N-1 so the error pulse lands exactly N clocks after a reload.
  localparam logic [TW-1:0]   TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      STOP_EDGE = 4'(PS2_FRAME_EDGES - 2);

  logic clk_level, clk_fe, data_level, data_fe_unused;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk    (clk),
    .resetn (resetn),
    .pad    (ps2clk_in),
    .level  (clk_level),
    .fe     (clk_fe)
  );

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk    (clk),
    .resetn (resetn),
    .pad    (ps2data_in),
    .level  (data_level),
    .fe     (data_fe_unused)
  );

  ps2_state_e    state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          ack_err_q, ack_err_d;
  logic          tmo_err_q, tmo_err_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      data_q    <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_err_d = 1'b0;
    tmo_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // The cycle in which done is high is not a request window.
        if (tx_start && !done_q) begin
          data_d    = tx_data;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          inh_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = ~PS2_START;
          tmo_cnt_d = TMO_LOAD;
          state_d   = SEND;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (clk_fe) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < 4'd8) begin
            data_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_cnt_q == 4'd8) begin
            data_oe_d = ~odd_parity(data_q);
          end else if (bit_cnt_q == STOP_EDGE) begin
            data_oe_d = ~PS2_STOP;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        if (clk_fe) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (!data_level) begin
            state_d = WAIT_IDLE;
          end else begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            ack_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (clk_level && data_level) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Device watchdog; expiry overrides any other outcome of the same cycle.
    if (state_q inside {SEND, ACK, WAIT_IDLE}) begin
      if (clk_fe) begin
        tmo_cnt_d = TMO_LOAD;
      end else if (tmo_cnt_q == '0) begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        tmo_err_d = 1'b1;
        state_d   = IDLE;
      end else begin
        tmo_cnt_d = tmo_cnt_q - 1'b1;
      end
    end
  end

  assign ps2clk_oe   = clk_oe_q;
  assign ps2data_oe  = data_oe_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign ack_err     = ack_err_q;
  assign timeout_err = tmo_err_q;
  assign state_dbg   = state_q;

endmodule
